// File: rtl/mips_pkg.sv
// Shared pipeline definitions: control-field widths, control-bit positions
// and ALUOp encodings used by the ID/EX stage and its neighbours.
package mips_pkg;

   // Control bundle widths
   localparam int WB_W = 2;
   localparam int M_W  = 3;
   localparam int EX_W = 4;

   // Write-back control bits
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   // Memory control bits
   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   // Execute control bits
   localparam int EX_ALUSRC   = 3;
   localparam int EX_ALUOP_HI = 2;
   localparam int EX_ALUOP_LO = 1;
   localparam int EX_REGDST   = 0;

   // ALUOp encodings driven by the main decoder
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,  // lw / sw address add
      ALUOP_SUB   = 2'b01,  // beq compare
      ALUOP_FUNCT = 2'b10   // R-type, ALU control decodes funct
   } aluop_e;

   // True when a memory-control bundle describes a load
   function automatic logic is_load(input logic [M_W-1:0] m_ctl);
      return m_ctl[M_MEMREAD];
   endfunction

endpackage

// File: rtl/id_ex_latch_if.sv
// ID-side inputs and EX-side outputs of the ID/EX pipeline register.
// master = surrounding pipeline, slave = the ID/EX latch itself.
interface id_ex_latch_if
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
);
   // ID stage side
   logic [WB_W-1:0]   wb_ctl_in;
   logic [M_W-1:0]    m_ctl_in;
   logic [EX_W-1:0]   ex_ctl_in;
   logic [DATA_W-1:0] npc_in;
   logic [DATA_W-1:0] rdata1_in;
   logic [DATA_W-1:0] rdata2_in;
   logic [DATA_W-1:0] s_extend_in;
   logic [REG_W-1:0]  instr_2521_in;
   logic [REG_W-1:0]  instr_2016_in;
   logic [REG_W-1:0]  instr_1511_in;
   logic              flush;

   // EX stage side
   logic [WB_W-1:0]   wb_ctlout;
   logic [M_W-1:0]    m_ctlout;
   logic [EX_W-1:0]   ex_ctlout;
   logic [DATA_W-1:0] npcout;
   logic [DATA_W-1:0] rdata1out;
   logic [DATA_W-1:0] rdata2out;
   logic [DATA_W-1:0] s_extendout;
   logic [REG_W-1:0]  instrout_2016;
   logic [REG_W-1:0]  instrout_1511;
   logic              ex_valid;
   logic              stall;
   logic [CNT_W-1:0]  bubble_count;

   modport master (
      output wb_ctl_in, m_ctl_in, ex_ctl_in, npc_in, rdata1_in, rdata2_in,
             s_extend_in, instr_2521_in, instr_2016_in, instr_1511_in, flush,
      input  wb_ctlout, m_ctlout, ex_ctlout, npcout, rdata1out, rdata2out,
             s_extendout, instrout_2016, instrout_1511, ex_valid, stall,
             bubble_count
   );

   modport slave (
      input  wb_ctl_in, m_ctl_in, ex_ctl_in, npc_in, rdata1_in, rdata2_in,
             s_extend_in, instr_2521_in, instr_2016_in, instr_1511_in, flush,
      output wb_ctlout, m_ctlout, ex_ctlout, npcout, rdata1out, rdata2out,
             s_extendout, instrout_2016, instrout_1511, ex_valid, stall,
             bubble_count
   );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a valid load in EX whose rt matches either
// source field of the ID instruction forces one bubble. A flush in the
// same cycle kills the ID instruction anyway, so no stall is requested.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             ex_memread,
   input  logic             ex_valid,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             flush,
   output logic             hazard,
   output logic             stall
);

   // rt is compared even for instructions that do not read it; the
   // occasional extra bubble is cheaper than decoding operand usage here.
   assign hazard = ex_memread & ex_valid & (ex_rt != '0) &
                   ((ex_rt == id_rs) | (ex_rt == id_rt));

   assign stall = hazard & ~flush;

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with integrated load-use bubble insertion,
// branch flush and a saturating bubble counter for performance debug.
module id_ex_latch
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input logic           clk,
   input logic           rst_n,
   id_ex_latch_if.slave  bus
);

   logic [WB_W-1:0]   wb_ctl_reg;
   logic [M_W-1:0]    m_ctl_reg;
   logic [EX_W-1:0]   ex_ctl_reg;
   logic [DATA_W-1:0] npc_reg;
   logic [DATA_W-1:0] rdata1_reg;
   logic [DATA_W-1:0] rdata2_reg;
   logic [DATA_W-1:0] s_extend_reg;
   logic [REG_W-1:0]  rt_reg;
   logic [REG_W-1:0]  rd_reg;
   logic              ex_valid_reg;
   logic [CNT_W-1:0]  bubble_count_reg;

   logic ex_memread;
   logic hazard;
   logic stall;
   logic bubble;

   assign ex_memread = is_load(m_ctl_reg);

   hazard_detect #(
      .REG_W (REG_W)
   ) u_hazard_detect (
      .ex_memread (ex_memread),
      .ex_valid   (ex_valid_reg),
      .ex_rt      (rt_reg),
      .id_rs      (bus.instr_2521_in),
      .id_rt      (bus.instr_2016_in),
      .flush      (bus.flush),
      .hazard     (hazard),
      .stall      (stall)
   );

   // Flush and hazard both turn the captured instruction into a bubble
   assign bubble = bus.flush | hazard;

   // Pipeline register: data always captured, controls zeroed on a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ctl_reg   <= '0;
         m_ctl_reg    <= '0;
         ex_ctl_reg   <= '0;
         npc_reg      <= '0;
         rdata1_reg   <= '0;
         rdata2_reg   <= '0;
         s_extend_reg <= '0;
         rt_reg       <= '0;
         rd_reg       <= '0;
         ex_valid_reg <= 1'b0;
      end else begin
         npc_reg      <= bus.npc_in;
         rdata1_reg   <= bus.rdata1_in;
         rdata2_reg   <= bus.rdata2_in;
         s_extend_reg <= bus.s_extend_in;
         rt_reg       <= bus.instr_2016_in;
         rd_reg       <= bus.instr_1511_in;
         if (bubble) begin
            wb_ctl_reg   <= '0;
            m_ctl_reg    <= '0;
            ex_ctl_reg   <= '0;
            ex_valid_reg <= 1'b0;
         end else begin
            wb_ctl_reg   <= bus.wb_ctl_in;
            m_ctl_reg    <= bus.m_ctl_in;
            ex_ctl_reg   <= bus.ex_ctl_in;
            ex_valid_reg <= 1'b1;
         end
      end
   end

   // Count only load-use bubbles (flush-killed cycles excluded), saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_count_reg <= '0;
      end else if (stall && (bubble_count_reg != {CNT_W{1'b1}})) begin
         bubble_count_reg <= bubble_count_reg + 1'b1;
      end
   end

   assign bus.wb_ctlout     = wb_ctl_reg;
   assign bus.m_ctlout      = m_ctl_reg;
   assign bus.ex_ctlout     = ex_ctl_reg;
   assign bus.npcout        = npc_reg;
   assign bus.rdata1out     = rdata1_reg;
   assign bus.rdata2out     = rdata2_reg;
   assign bus.s_extendout   = s_extend_reg;
   assign bus.instrout_2016 = rt_reg;
   assign bus.instrout_1511 = rd_reg;
   assign bus.ex_valid      = ex_valid_reg;
   assign bus.stall         = stall;
   assign bus.bubble_count  = bubble_count_reg;

endmodule
